// File: rtl/trd_sched.sv
// trd_sched: thread lifecycle (valid/run state, parent->child masks, spawn allocation, overflow flag)
// and round-robin fetch scheduler. Optional macro TRD_QUANTUM_EN holds a thread for QUANTUM fetch cycles.
module trd_sched #(
    parameter int NUM_TRD = 8,
    parameter int TRD_W   = 3,
    parameter int QUANTUM = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       spawn_req,
    input  logic [TRD_W-1:0]           spawn_parent,
    output logic                       spawn_ack,
    output logic                       spawn_nack,
    output logic [TRD_W-1:0]           spawn_child,
    input  logic                       end_req,
    input  logic [TRD_W-1:0]           end_trd,
    input  logic                       exc_vld,
    input  logic [TRD_W-1:0]           exc_trd,
    input  logic                       resume_vld,
    input  logic [TRD_W-1:0]           resume_trd,
    input  logic                       clr_of,
    input  logic                       fetch_stall,
    output logic                       fetch_vld,
    output logic [TRD_W-1:0]           insfetch_trd,
    output logic [NUM_TRD-1:0]         valid_trd,
    output logic [NUM_TRD-1:0]         run_trd,
    output logic                       running,
    output logic                       trd_full,
    output logic                       trd_of,
    output logic [NUM_TRD*NUM_TRD-1:0] child_mask
);

    logic [NUM_TRD-1:0]              valid_q, valid_d, run_q, run_d;
    logic [NUM_TRD-1:0][NUM_TRD-1:0] child_q, child_d;
    logic                            trd_of_q, trd_of_d;
    logic                            spawn_ack_q, spawn_ack_d, spawn_nack_q, spawn_nack_d;
    logic [TRD_W-1:0]                spawn_child_q, spawn_child_d;
    logic                            fetch_vld_q, fetch_vld_d;
    logic [TRD_W-1:0]                ins_q, ins_d;
    logic [NUM_TRD-1:0]              kill_mask, eligible;
    logic [TRD_W-1:0]                free_idx, rr_idx;
    logic                            free_found, spawn_ok;

`ifdef TRD_QUANTUM_EN
    localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_quantum;
    assign unused_quantum = ^QUANTUM;
`endif

    // Threads ended or halted this cycle must not be picked for fetch.
    always_comb begin
        kill_mask = '0;
        if (end_req) kill_mask[end_trd] = 1'b1;
        if (exc_vld) kill_mask[exc_trd] = 1'b1;
        eligible = run_q & ~kill_mask;
    end

    // Lowest free slot from pre-edge state; descending scan lets the lowest index win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_TRD - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = TRD_W'(i);
            end
        end
    end

    always_comb begin
        valid_d       = valid_q;
        run_d         = run_q;
        child_d       = child_q;
        spawn_ack_d   = 1'b0;
        spawn_nack_d  = 1'b0;
        spawn_child_d = '0;
        trd_of_d      = trd_of_q & ~clr_of;
        spawn_ok      = spawn_req && valid_q[spawn_parent] && !(end_req && (end_trd == spawn_parent));

        // Applied lowest priority first so end > exc > resume on the same thread.
        if (resume_vld && valid_q[resume_trd]) run_d[resume_trd] = 1'b1;
        if (exc_vld) run_d[exc_trd] = 1'b0;
        if (end_req) begin
            valid_d[end_trd] = 1'b0;
            run_d[end_trd]   = 1'b0;
            child_d[end_trd] = '0;
            for (int p = 0; p < NUM_TRD; p++) child_d[p][end_trd] = 1'b0;
        end

        if (start && (valid_q == '0)) begin
            valid_d[0] = 1'b1;
            run_d[0]   = 1'b1;
        end

        if (spawn_ok) begin
            if (free_found) begin
                valid_d[free_idx]               = 1'b1;
                run_d[free_idx]                 = 1'b1;
                child_d[spawn_parent][free_idx] = 1'b1;
                spawn_ack_d                     = 1'b1;
                spawn_child_d                   = free_idx;
            end else begin
                spawn_nack_d = 1'b1;
                trd_of_d     = 1'b1;
            end
        end
    end

    // First eligible id strictly after the current one, circular; k == NUM_TRD revisits the current id.
    always_comb begin
        rr_idx = ins_q;
        for (int k = NUM_TRD; k >= 1; k--) begin
            if (eligible[TRD_W'((int'(ins_q) + k) % NUM_TRD)]) rr_idx = TRD_W'((int'(ins_q) + k) % NUM_TRD);
        end
    end

    always_comb begin
        ins_d       = ins_q;
        fetch_vld_d = fetch_vld_q & eligible[ins_q];
`ifdef TRD_QUANTUM_EN
        cnt_d = cnt_q;
`endif
        if (!fetch_stall) begin
            fetch_vld_d = |eligible;
`ifdef TRD_QUANTUM_EN
            if (fetch_vld_q && eligible[ins_q] && (int'(cnt_q) < QUANTUM - 1)) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
                ins_d = rr_idx;
            end
`else
            ins_d = rr_idx;
`endif
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            run_q         <= '0;
            child_q       <= '0;
            trd_of_q      <= 1'b0;
            spawn_ack_q   <= 1'b0;
            spawn_nack_q  <= 1'b0;
            spawn_child_q <= '0;
            fetch_vld_q   <= 1'b0;
            ins_q         <= '0;
`ifdef TRD_QUANTUM_EN
            cnt_q         <= '0;
`endif
        end else begin
            valid_q       <= valid_d;
            run_q         <= run_d;
            child_q       <= child_d;
            trd_of_q      <= trd_of_d;
            spawn_ack_q   <= spawn_ack_d;
            spawn_nack_q  <= spawn_nack_d;
            spawn_child_q <= spawn_child_d;
            fetch_vld_q   <= fetch_vld_d;
            ins_q         <= ins_d;
`ifdef TRD_QUANTUM_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign spawn_ack    = spawn_ack_q;
    assign spawn_nack   = spawn_nack_q;
    assign spawn_child  = spawn_child_q;
    assign fetch_vld    = fetch_vld_q;
    assign insfetch_trd = ins_q;
    assign valid_trd    = valid_q;
    assign run_trd      = run_q;
    assign running      = |run_q;
    assign trd_full     = &valid_q;
    assign trd_of       = trd_of_q;
    assign child_mask   = child_q;

endmodule
